// File: rtl/ni_flit_packetizer_if.sv
// Packet request, body word, flit output and credit signals between core, packetizer and router port.
// No logic: wiring bundle only; the slave modport is the packetizer's view.
// Backpressure: pkt_ready/body_ready from the packetizer, credits from the router FIFO.
interface ni_flit_packetizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 4
);
  logic                  pkt_valid;
  logic [3:0]            pkt_dst;
  logic [LEN_W-1:0]      pkt_len;
  logic                  pkt_ready;
  logic                  body_valid;
  logic [DATA_WIDTH-1:0] body_data;
  logic                  body_ready;
  logic                  flit_valid;
  logic [2:0]            flit_id;
  logic [3:0]            flit_dst;
  logic [DATA_WIDTH-1:0] flit_data;
  logic                  credit_in;
  logic                  credit_err;

  modport master (
    output pkt_valid, pkt_dst, pkt_len, body_valid, body_data, credit_in,
    input  pkt_ready, body_ready, flit_valid, flit_id, flit_dst, flit_data, credit_err
  );

  modport slave (
    input  pkt_valid, pkt_dst, pkt_len, body_valid, body_data, credit_in,
    output pkt_ready, body_ready, flit_valid, flit_id, flit_dst, flit_data, credit_err
  );
endinterface

// File: rtl/ni_flit_packetizer.sv
// Turns a (dst, N) request plus N body words into HEADER / PAYLOAD* / TAIL flits for the local router port.
// Latency: flit registered one cycle after its send decision; one flit per cycle sustained, one idle cycle per packet.
// Backpressure: nothing is sent without a downstream credit; body_ready drops when credits run out.
module ni_flit_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 4,
  parameter int CREDITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           src_addr,
  ni_flit_packetizer_if.slave  nif
);

  localparam logic [2:0] ID_HEADER  = 3'b001;
  localparam logic [2:0] ID_PAYLOAD = 3'b010;
  localparam logic [2:0] ID_TAIL    = 3'b100;
  localparam logic [3:0] CRED_MAX   = 4'(CREDITS);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_t;

  state_t                state_q, state_d;
  logic [3:0]            dst_q, dst_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  flit_vld_q, flit_vld_d;
  logic [2:0]            flit_id_q, flit_id_d;
  logic [3:0]            flit_dst_q, flit_dst_d;
  logic [DATA_WIDTH-1:0] flit_dat_q, flit_dat_d;

  logic                  send;
  logic                  has_credit;
  logic                  pkt_rdy;
  logic                  body_rdy;
  logic [DATA_WIDTH-1:0] hdr_dat;

  assign has_credit = (cnt_q != 4'd0);

  // Header word: dst in [3:0], own address in [7:4], body length above that, zero elsewhere.
  always_comb begin
    hdr_dat             = '0;
    hdr_dat[3:0]        = dst_q;
    hdr_dat[7:4]        = src_addr;
    hdr_dat[8 +: LEN_W] = len_q;
  end

  // Packet sequencing: decides which flit (if any) goes out this cycle and what it carries.
  always_comb begin
    state_d    = state_q;
    dst_d      = dst_q;
    len_d      = len_q;
    rem_d      = rem_q;
    flit_dst_d = flit_dst_q;
    send       = 1'b0;
    flit_id_d  = 3'b000;
    flit_dat_d = '0;
    pkt_rdy    = 1'b0;
    body_rdy   = 1'b0;
    case (state_q)
      S_IDLE: begin
        pkt_rdy = 1'b1;
        if (nif.pkt_valid) begin
          dst_d   = nif.pkt_dst;
          len_d   = nif.pkt_len;
          rem_d   = nif.pkt_len;
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        if (has_credit) begin
          send       = 1'b1;
          flit_id_d  = ID_HEADER;
          flit_dat_d = hdr_dat;
          flit_dst_d = dst_q;
          state_d    = (len_q >= LEN_W'(2)) ? S_BODY : S_TAIL;
        end
      end
      S_BODY: begin
        body_rdy = has_credit;
        if (body_rdy && nif.body_valid) begin
          send       = 1'b1;
          flit_id_d  = ID_PAYLOAD;
          flit_dat_d = nif.body_data;
          rem_d      = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(2)) state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (len_q == '0) begin
          // Empty packet: the tail carries zero and no body word is consumed.
          if (has_credit) begin
            send      = 1'b1;
            flit_id_d = ID_TAIL;
            state_d   = S_IDLE;
          end
        end else begin
          body_rdy = has_credit;
          if (body_rdy && nif.body_valid) begin
            send       = 1'b1;
            flit_id_d  = ID_TAIL;
            flit_dat_d = nif.body_data;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    flit_vld_d = send;
  end

  // Credit accounting: a send and a returned credit in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (send && !nif.credit_in) begin
      cnt_d = cnt_q - 4'd1;
    end else if (!send && nif.credit_in) begin
      if (cnt_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // State, credit and flit output registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      dst_q      <= 4'd0;
      len_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= CRED_MAX;
      err_q      <= 1'b0;
      flit_vld_q <= 1'b0;
      flit_id_q  <= 3'b000;
      flit_dst_q <= 4'd0;
      flit_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      flit_vld_q <= flit_vld_d;
      flit_id_q  <= flit_id_d;
      flit_dst_q <= flit_dst_d;
      flit_dat_q <= flit_dat_d;
    end
  end

  // Ready strobes are forced low while reset is held so every output reads zero.
  assign nif.pkt_ready  = pkt_rdy & rst;
  assign nif.body_ready = body_rdy & rst;
  assign nif.flit_valid = flit_vld_q;
  assign nif.flit_id    = flit_id_q;
  assign nif.flit_dst   = flit_dst_q;
  assign nif.flit_data  = flit_dat_q;
  assign nif.credit_err = err_q;

endmodule

// File: tb/tb_ni_flit_packetizer.sv
module tb_ni_flit_packetizer;

  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] PAY = 3'b010;
  localparam logic [2:0] TL  = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] src = 4'h5;
  logic echo_en = 1'b0;
  logic credit_man = 1'b0;
  int   cyc = 0;
  int   br_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  logic [2:0]  m_id[$];
  logic [31:0] m_dat[$];
  logic [3:0]  m_dst[$];
  int          m_cyc[$];

  logic [31:0] bw[16];
  int          hs_cyc[16];
  int          bw_n = 0;
  int          bidx = 0;
  bit          toggle = 1'b0;
  bit          phase = 1'b0;
  bit          pkt_pend = 1'b0;
  logic [3:0]  pd = 4'h0;
  logic [3:0]  pl = 4'h0;

  always #5 clk = ~clk;

  ni_flit_packetizer_if #(.DATA_WIDTH(32), .LEN_W(4)) nif ();

  assign nif.credit_in = echo_en ? nif.flit_valid : credit_man;

  ni_flit_packetizer #(.DATA_WIDTH(32), .LEN_W(4), .CREDITS(4)) dut (
    .clk      (clk),
    .rst      (rst_n),
    .src_addr (src),
    .nif      (nif)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nif.flit_valid === 1'b1) begin
      m_id.push_back(nif.flit_id);
      m_dat.push_back(nif.flit_data);
      m_dst.push_back(nif.flit_dst);
      m_cyc.push_back(cyc);
    end
    if (nif.body_ready === 1'b1) br_cnt <= br_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      nif.pkt_valid = pkt_pend;
      nif.pkt_dst   = pkt_pend ? pd : 4'h0;
      nif.pkt_len   = pkt_pend ? pl : 4'h0;
      if (pkt_pend && nif.pkt_ready === 1'b1) pkt_pend = 1'b0;
      phase = ~phase;
      if (bidx < bw_n && (!toggle || phase)) begin
        nif.body_valid = 1'b1;
        nif.body_data  = bw[bidx];
      end else begin
        nif.body_valid = 1'b0;
        nif.body_data  = 32'h0;
      end
      if (nif.body_valid && nif.body_ready === 1'b1) begin
        hs_cyc[bidx] = cyc;
        bidx++;
      end
    end
  endtask

  task automatic start_pkt(input logic [3:0] dst, input logic [3:0] len);
    pd = dst; pl = len; pkt_pend = 1'b1; bw_n = int'(len); bidx = 0;
  endtask

  task automatic wait_flits(input int want, input int budget);
    int k = 0;
    while (m_id.size() < want && k < budget) begin
      run_cycles(1);
      k++;
    end
  endtask

  task automatic pulse_credit();
    credit_man = 1'b1;
    run_cycles(1);
    credit_man = 1'b0;
  endtask

  task automatic test_reset();
    nif.pkt_valid = 1'b0; nif.pkt_dst = 4'h0; nif.pkt_len = 4'h0;
    nif.body_valid = 1'b0; nif.body_data = 32'h0;
    rst_n = 1'b0;
    #12;
    tests++; if (nif.pkt_ready !== 1'b0) begin fails++; $display("FAIL reset_pkt_ready: got %b want 0", nif.pkt_ready); end
    tests++; if (nif.body_ready !== 1'b0) begin fails++; $display("FAIL reset_body_ready: got %b want 0", nif.body_ready); end
    tests++; if (nif.flit_valid !== 1'b0) begin fails++; $display("FAIL reset_flit_valid: got %b want 0", nif.flit_valid); end
    tests++; if (nif.flit_id !== 3'b000) begin fails++; $display("FAIL reset_flit_id: got %b want 000", nif.flit_id); end
    tests++; if (nif.flit_data !== 32'h0 || nif.flit_dst !== 4'h0) begin fails++; $display("FAIL reset_flit_data_dst: got %h/%h want 0/0", nif.flit_data, nif.flit_dst); end
    tests++; if (nif.credit_err !== 1'b0) begin fails++; $display("FAIL reset_credit_err: got %b want 0", nif.credit_err); end
    @(negedge clk); #1 rst_n = 1'b1;
    run_cycles(1);
    tests++; if (nif.pkt_ready !== 1'b1) begin fails++; $display("FAIL idle_pkt_ready: got %b want 1", nif.pkt_ready); end
  endtask

  task automatic test_basic();
    int base;
    logic [2:0]  eid[4];
    logic [31:0] edat[4];
    eid  = '{HDR, PAY, PAY, TL};
    edat = '{32'h35A, 32'h11, 32'h22, 32'h33};
    echo_en = 1'b1; toggle = 1'b0;
    bw[0] = 32'h11; bw[1] = 32'h22; bw[2] = 32'h33;
    base = m_id.size();
    start_pkt(4'hA, 4'd3);
    wait_flits(base + 4, 40);
    tests++; if (m_id.size() != base + 4) begin fails++; $display("FAIL basic_count: got %0d want 4", m_id.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (m_id[base+i] !== eid[i]) begin fails++; $display("FAIL basic_id[%0d]: got %b want %b", i, m_id[base+i], eid[i]); end
        tests++; if (m_dat[base+i] !== edat[i]) begin fails++; $display("FAIL basic_data[%0d]: got %h want %h", i, m_dat[base+i], edat[i]); end
        tests++; if (m_dst[base+i] !== 4'hA) begin fails++; $display("FAIL basic_dst[%0d]: got %h want a", i, m_dst[base+i]); end
        tests++; if (m_cyc[base+i] != m_cyc[base] + i) begin fails++; $display("FAIL basic_consecutive[%0d]: got cycle %0d want %0d", i, m_cyc[base+i], m_cyc[base] + i); end
      end
    end
    run_cycles(5);
  endtask

  task automatic test_credit_stall();
    int base;
    echo_en = 1'b0; credit_man = 1'b0; toggle = 1'b0;
    for (int i = 0; i < 7; i++) bw[i] = 32'h70 + i;
    base = m_id.size();
    start_pkt(4'h3, 4'd7);
    run_cycles(20);
    tests++; if (m_id.size() != base + 4) begin fails++; $display("FAIL stall_count: got %0d want 4", m_id.size() - base); end
    tests++; if (m_id.size() >= base + 1 && m_dat[base] !== 32'h753) begin fails++; $display("FAIL stall_header: got %h want 753", m_dat[base]); end
    pulse_credit(); run_cycles(2);
    pulse_credit(); run_cycles(5);
    tests++; if (m_id.size() != base + 6) begin fails++; $display("FAIL stall_two_credits: got %0d want 6", m_id.size() - base); end
    pulse_credit(); pulse_credit(); run_cycles(5);
    tests++; if (m_id.size() != base + 8) begin fails++; $display("FAIL stall_total: got %0d want 8", m_id.size() - base); end
    else begin
      for (int i = 1; i < 8; i++) begin
        tests++; if (m_dat[base+i] !== 32'h70 + i - 1 || m_id[base+i] !== (i == 7 ? TL : PAY)) begin
          fails++; $display("FAIL stall_flit[%0d]: got id %b data %h want id %b data %h", i, m_id[base+i], m_dat[base+i], (i == 7 ? TL : PAY), 32'h70 + i - 1);
        end
      end
    end
    for (int i = 0; i < 4; i++) pulse_credit();
    run_cycles(2);
  endtask

  task automatic test_loopback_zero();
    int base, br0;
    echo_en = 1'b1;
    base = m_id.size();
    run_cycles(1);
    br0 = br_cnt;
    start_pkt(4'h5, 4'd0);
    wait_flits(base + 2, 30);
    run_cycles(4);
    tests++; if (m_id.size() != base + 2) begin fails++; $display("FAIL zero_count: got %0d want 2", m_id.size() - base); end
    else begin
      tests++; if (m_id[base] !== HDR || m_dat[base] !== 32'h055) begin fails++; $display("FAIL zero_header: got %b/%h want %b/055", m_id[base], m_dat[base], HDR); end
      tests++; if (m_id[base+1] !== TL || m_dat[base+1] !== 32'h0) begin fails++; $display("FAIL zero_tail: got %b/%h want %b/0", m_id[base+1], m_dat[base+1], TL); end
      tests++; if (m_dst[base+1] !== 4'h5) begin fails++; $display("FAIL zero_dst: got %h want 5", m_dst[base+1]); end
    end
    tests++; if (br_cnt != br0) begin fails++; $display("FAIL zero_body_ready: got %0d ready cycles want 0", br_cnt - br0); end
  endtask

  task automatic test_body_gaps();
    int base;
    echo_en = 1'b1; toggle = 1'b1;
    for (int i = 0; i < 4; i++) bw[i] = 32'hA0 + i;
    base = m_id.size();
    start_pkt(4'hC, 4'd4);
    wait_flits(base + 5, 60);
    run_cycles(4);
    tests++; if (m_id.size() != base + 5) begin fails++; $display("FAIL gaps_count: got %0d want 5", m_id.size() - base); end
    else begin
      tests++; if (m_id[base] !== HDR || m_dat[base] !== 32'h45C) begin fails++; $display("FAIL gaps_header: got %b/%h want %b/45c", m_id[base], m_dat[base], HDR); end
      for (int i = 1; i < 5; i++) begin
        tests++; if (m_id[base+i] !== (i == 4 ? TL : PAY) || m_dat[base+i] !== 32'hA0 + i - 1) begin
          fails++; $display("FAIL gaps_flit[%0d]: got %b/%h want %b/%h", i, m_id[base+i], m_dat[base+i], (i == 4 ? TL : PAY), 32'hA0 + i - 1);
        end
        tests++; if (m_cyc[base+i] != hs_cyc[i-1] + 1) begin fails++; $display("FAIL gaps_timing[%0d]: got cycle %0d want %0d", i, m_cyc[base+i], hs_cyc[i-1] + 1); end
      end
    end
    toggle = 1'b0;
  endtask

  task automatic test_credit_err();
    int base;
    echo_en = 1'b0; credit_man = 1'b0;
    run_cycles(3);
    tests++; if (nif.credit_err !== 1'b0) begin fails++; $display("FAIL err_before: got %b want 0", nif.credit_err); end
    pulse_credit(); run_cycles(1);
    tests++; if (nif.credit_err !== 1'b1) begin fails++; $display("FAIL err_set: got %b want 1", nif.credit_err); end
    for (int i = 0; i < 7; i++) bw[i] = 32'hB0 + i;
    base = m_id.size();
    start_pkt(4'h9, 4'd7);
    run_cycles(1);
    run_cycles(1);
    // Credit lands on the same edge the header is sent.
    pulse_credit();
    run_cycles(20);
    tests++; if (m_id.size() != base + 5) begin fails++; $display("FAIL err_saturate_and_cancel: got %0d flits want 5", m_id.size() - base); end
    tests++; if (m_id.size() >= base + 1 && (m_id[base] !== HDR || m_dat[base] !== 32'h759)) begin fails++; $display("FAIL err_header: got %b/%h want %b/759", m_id[base], m_dat[base], HDR); end
    for (int i = 0; i < 3; i++) pulse_credit();
    run_cycles(5);
    tests++; if (m_id.size() != base + 8 || m_id[m_id.size()-1] !== TL || m_dat[m_dat.size()-1] !== 32'hB6) begin
      fails++; $display("FAIL err_finish: got %0d flits last %b/%h want 8 %b/b6", m_id.size() - base, m_id[m_id.size()-1], m_dat[m_dat.size()-1], TL);
    end
    tests++; if (nif.credit_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", nif.credit_err); end
    for (int i = 0; i < 4; i++) pulse_credit();
    run_cycles(2);
  endtask

  task automatic test_reset_midpacket();
    int base;
    echo_en = 1'b1;
    for (int i = 0; i < 5; i++) bw[i] = 32'hC0 + i;
    base = m_id.size();
    start_pkt(4'h6, 4'd5);
    wait_flits(base + 2, 30);
    tests++; if (m_id.size() < base + 2) begin fails++; $display("FAIL mid_start: got %0d flits want 2", m_id.size() - base); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (nif.flit_valid !== 1'b0 || nif.flit_id !== 3'b000 || nif.flit_data !== 32'h0 || nif.flit_dst !== 4'h0) begin
      fails++; $display("FAIL mid_flit_clear: got %b/%b/%h/%h want all 0", nif.flit_valid, nif.flit_id, nif.flit_data, nif.flit_dst);
    end
    tests++; if (nif.pkt_ready !== 1'b0 || nif.body_ready !== 1'b0 || nif.credit_err !== 1'b0) begin
      fails++; $display("FAIL mid_ctrl_clear: got %b/%b/%b want 0/0/0", nif.pkt_ready, nif.body_ready, nif.credit_err);
    end
    pkt_pend = 1'b0; bw_n = 0; bidx = 0;
    nif.pkt_valid = 1'b0; nif.body_valid = 1'b0;
    echo_en = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b1;
    base = m_id.size();
    for (int i = 0; i < 3; i++) bw[i] = 32'hD0 + i;
    start_pkt(4'hE, 4'd3);
    run_cycles(20);
    tests++; if (m_id.size() != base + 4) begin fails++; $display("FAIL mid_full_credits: got %0d flits want 4", m_id.size() - base); end
    else begin
      tests++; if (m_id[base] !== HDR || m_dat[base] !== 32'h35E || m_dst[base] !== 4'hE) begin
        fails++; $display("FAIL mid_new_header: got %b/%h/%h want %b/35e/e", m_id[base], m_dat[base], m_dst[base], HDR);
      end
      tests++; if (m_id[base+3] !== TL || m_dat[base+3] !== 32'hD2) begin fails++; $display("FAIL mid_new_tail: got %b/%h want %b/d2", m_id[base+3], m_dat[base+3], TL); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_stall();
    test_loopback_zero();
    test_body_gaps();
    test_credit_err();
    test_reset_midpacket();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
